// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the single D-bus interconnect port between the rv_core
// data port (core) and the debug-module system-bus port (dm). One transaction
// is outstanding at a time. Ties are broken round-robin or with fixed dm
// priority. A bus timeout force-completes a transfer with an error so a dead
// slave cannot hang either master.
module dbus_arbiter #(
  parameter bit          FIXED_DM_PRIO = 1'b0,
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned TW            = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  // core master
  input  logic        core_req,
  input  logic        core_we,
  input  logic [1:0]  core_size,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_done,
  output logic        core_err,
  // debug-module master
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_err,
  // interconnect side
  output logic        s_req,
  output logic        s_we,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_done,
  // status
  output logic        busy,
  output logic        grant_dm
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_CORE = 2'd1,
    BUSY_DM   = 2'd2
  } state_e;

  // Last counter value of a transfer; unused (and harmless) when TIMEOUT = 0.
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e        state_q, state_d;
  logic          grant_dm_q, grant_dm_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic          pick_dm;
  logic          expire;
  logic          in_busy;

  assign in_busy = (state_q != IDLE);
  assign expire  = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // Next-state: arbitrate and capture the winner in IDLE, run the timeout in BUSY.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    grant_dm_d = grant_dm_q;
    we_d       = we_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    pick_dm    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (core_req || dm_req) begin
          if (core_req && dm_req) begin
            pick_dm = FIXED_DM_PRIO ? 1'b1 : !grant_dm_q;
          end else begin
            pick_dm = dm_req;
          end
          grant_dm_d = pick_dm;
          we_d       = pick_dm ? dm_we    : core_we;
          size_d     = pick_dm ? dm_size  : core_size;
          addr_d     = pick_dm ? dm_addr  : core_addr;
          wdata_d    = pick_dm ? dm_wdata : core_wdata;
          state_d    = pick_dm ? BUSY_DM  : BUSY_CORE;
        end
      end
      BUSY_CORE, BUSY_DM: begin
        if (s_done || expire) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_dm_q <= 1'b0;
      cnt_q      <= '0;
      // NOTE: the captured request fields are a handful of flops, not a
      // memory, so they are reset too and never drive X onto the bus.
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_dm_q <= grant_dm_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Completion steering: only the owner of the transfer sees done/err/rdata;
  // a reset cycle suppresses any completion.
  always_comb begin
    core_done  = 1'b0;
    core_err   = 1'b0;
    core_rdata = '0;
    dm_done    = 1'b0;
    dm_err     = 1'b0;
    dm_rdata   = '0;
    if (rst_n && in_busy && (s_done || expire)) begin
      if (state_q == BUSY_DM) begin
        dm_done  = 1'b1;
        dm_err   = !s_done;
        dm_rdata = s_done ? s_rdata : '0;
      end else begin
        core_done  = 1'b1;
        core_err   = !s_done;
        core_rdata = s_done ? s_rdata : '0;
      end
    end
  end

  assign s_req    = in_busy;
  assign s_we     = we_q;
  assign s_size   = size_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign busy     = in_busy;
  assign grant_dm = grant_dm_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Testbench for dbus_arbiter: table-driven arbitration bursts checked through
// a completion scoreboard, plus hand-written latency, timeout and reset cases.
module tb_dbus_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, core_done, core_err;
  logic [1:0]  core_size;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        dm_req, dm_we, dm_done, dm_err;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        s_req, s_we, s_done;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        busy, grant_dm;

  dbus_arbiter #(.FIXED_DM_PRIO(1'b0), .TIMEOUT(TO), .TW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_size(core_size),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_done(core_done), .core_err(core_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_done(dm_done), .dm_err(dm_err),
    .s_req(s_req), .s_we(s_we), .s_size(s_size), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_done(s_done),
    .busy(busy), .grant_dm(grant_dm)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dm;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    string      name;
    int         core_n;
    int         dm_n;
    int         lat;
    int         exp_n;
    logic [7:0] seq;   // bit i = 1: i-th grant goes to dm
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vecs[6];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          core_left = 0, dm_left = 0, core_k = 0, dm_k = 0;
  bit          slv_en = 1'b1, slv_fixed = 1'b0, slv_poke = 1'b0;
  int          slv_lat = 0, slv_cnt = 0;
  logic [31:0] slv_data = '0;
  bit          mon_on = 1'b0, prev_done = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(bit dm, int k);
    return (dm ? 32'h1000_0000 : 32'h2000_0000) + 32'(k * 16);
  endfunction

  function automatic logic [31:0] rd_of(logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic set_fields(bit dm, int k);
    logic [31:0] a;
    a = addr_of(dm, k);
    if (dm) begin
      dm_addr = a; dm_we = k[0]; dm_size = 2'(k % 3); dm_wdata = ~a;
    end else begin
      core_addr = a; core_we = k[0]; core_size = 2'(k % 3); core_wdata = ~a;
    end
  endtask

  // Slave model: answers s_req after slv_lat extra cycles; can be silenced,
  // or poked to emit a stray s_done while idle.
  initial begin
    s_done = 1'b0;
    s_rdata = '0;
    forever begin
      @(posedge clk); #1;
      s_done = 1'b0;
      s_rdata = '0;
      if (slv_poke) begin
        s_done = 1'b1; s_rdata = 32'hBAD0_BAD0; slv_poke = 1'b0;
      end else if (s_req && slv_en) begin
        if (slv_cnt >= slv_lat) begin
          s_done = 1'b1;
          s_rdata = slv_fixed ? slv_data : rd_of(s_addr);
          slv_cnt = 0;
        end else begin
          slv_cnt++;
        end
      end else begin
        slv_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every completion and advances the masters.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (prev_done) check("idle_after_done", {s_req, busy}, 2'b00);
        prev_done = core_done | dm_done;
        if (core_done || dm_done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", {dm_done, core_done}, 2'b00);
          end else begin
            mon_e = sb.pop_front();
            check("done_owner", {dm_done, core_done}, mon_e.dm ? 2'b10 : 2'b01);
            check("grant_dm", grant_dm, mon_e.dm);
            check("s_addr", s_addr, mon_e.addr);
            check("s_we_size", {s_we, s_size}, {mon_e.we, mon_e.size});
            check("s_wdata", s_wdata, mon_e.wdata);
            check("rdata", mon_e.dm ? dm_rdata : core_rdata, mon_e.rdata);
            check("err", mon_e.dm ? dm_err : core_err, mon_e.err);
            check("other_quiet", mon_e.dm ? {core_rdata, core_err} : {dm_rdata, dm_err}, 0);
          end
          if (dm_done) begin
            dm_k++; dm_left--;
            if (dm_left <= 0) begin dm_left = 0; dm_req = 1'b0; end
            else set_fields(1'b1, dm_k);
          end
          if (core_done) begin
            core_k++; core_left--;
            if (core_left <= 0) begin core_left = 0; core_req = 1'b0; end
            else set_fields(1'b0, core_k);
          end
        end else begin
          check("quiet", {core_rdata, dm_rdata, core_err, dm_err}, 0);
        end
      end
    end
  end

  task automatic drain(input string name);
    int cyc = 0;
    while ((sb.size() != 0 || core_left != 0 || dm_left != 0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_drain"}, sb.size() + core_left + dm_left, 0);
    if (cyc >= 400) begin
      sb.delete(); core_req = 1'b0; dm_req = 1'b0; core_left = 0; dm_left = 0;
    end
    repeat (2) @(negedge clk);
    check({name, "_idle"}, {busy, s_req}, 2'b00);
  endtask

  task automatic run_vec(input vec_t vv);
    int ck = core_k;
    int dk = dm_k;
    int kk;
    bit m;
    exp_t e;
    slv_lat = vv.lat;
    for (int i = 0; i < vv.exp_n; i++) begin
      m = vv.seq[i];
      if (m) begin kk = dk; dk++; end
      else begin kk = ck; ck++; end
      e.dm = m; e.addr = addr_of(m, kk); e.we = kk[0]; e.size = 2'(kk % 3);
      e.wdata = ~e.addr; e.rdata = rd_of(e.addr); e.err = 1'b0;
      sb.push_back(e);
    end
    core_left = vv.core_n;
    dm_left = vv.dm_n;
    if (vv.core_n > 0) begin set_fields(1'b0, core_k); core_req = 1'b1; end
    if (vv.dm_n > 0) begin set_fields(1'b1, dm_k); dm_req = 1'b1; end
    drain(vv.name);
  endtask

  initial begin
    int  cyc;
    bit  got;
    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_size = '0; core_addr = '0; core_wdata = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = '0; dm_addr = '0; dm_wdata = '0;

    vecs[0] = '{"both_from_reset", 1, 1, 1, 2, 8'b0000_0001};
    vecs[1] = '{"core_only",       1, 0, 2, 1, 8'b0000_0000};
    vecs[2] = '{"dm_only_twice",   0, 2, 0, 2, 8'b0000_0011};
    vecs[3] = '{"rr_six",          3, 3, 1, 6, 8'b0010_1010};
    vecs[4] = '{"rr_core2_dm1",    2, 1, 3, 3, 8'b0000_0010};
    vecs[5] = '{"dm_slow",         0, 1, 5, 1, 8'b0000_0001};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_req", s_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant_dm", grant_dm, 1'b0);
    check("rst_outputs", {core_done, dm_done, core_err, dm_err, core_rdata, dm_rdata}, 0);
    mon_on = 1'b1;

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Core word read: s_req one cycle after core_req, done two cycles after s_req.
    slv_fixed = 1'b1; slv_data = 32'hDEAD_BEEF; slv_lat = 2;
    sb.push_back('{dm: 1'b0, addr: 32'h2000_0010, we: 1'b0, size: 2'd2,
                   wdata: 32'h0, rdata: 32'hDEAD_BEEF, err: 1'b0});
    core_addr = 32'h2000_0010; core_we = 1'b0; core_size = 2'd2; core_wdata = '0;
    core_left = 1;
    @(posedge clk); #1 core_req = 1'b1;
    @(negedge clk); check("t1_s_req_low", s_req, 1'b0);
    @(negedge clk); check("t1_s_req_high", {s_req, grant_dm}, 2'b10);
    @(negedge clk); check("t1_no_done_yet", {core_done, dm_done}, 2'b00);
    @(negedge clk); check("t1_done", {core_done, dm_done}, 2'b10);
    drain("t1");
    slv_fixed = 1'b0;

    // Dead slave: error completion in the TO-th BUSY cycle with rdata 0.
    slv_en = 1'b0;
    sb.push_back('{dm: 1'b0, addr: 32'h2000_0100, we: 1'b1, size: 2'd1,
                   wdata: 32'h1234_5678, rdata: 32'h0, err: 1'b1});
    core_addr = 32'h2000_0100; core_we = 1'b1; core_size = 2'd1; core_wdata = 32'h1234_5678;
    core_left = 1;
    @(posedge clk); #1 core_req = 1'b1;
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (busy) cyc++;
      if (core_done) got = 1'b1;
    end
    check("t4_timeout_cycles", cyc, TO);
    @(negedge clk); check("t4_s_req_low", s_req, 1'b0);
    slv_en = 1'b1;
    drain("t4");

    // Stray s_done while idle must not start or complete anything.
    slv_poke = 1'b1;
    repeat (3) @(negedge clk);
    check("late_done_ignored", {busy, s_req, core_done, dm_done}, 0);

    // s_done coincides with timeout expiry: normal completion.
    slv_lat = TO - 1;
    sb.push_back('{dm: 1'b1, addr: 32'h1000_0200, we: 1'b0, size: 2'd2,
                   wdata: 32'h0, rdata: rd_of(32'h1000_0200), err: 1'b0});
    dm_addr = 32'h1000_0200; dm_we = 1'b0; dm_size = 2'd2; dm_wdata = '0;
    dm_left = 1;
    @(posedge clk); #1 dm_req = 1'b1;
    drain("t5");

    // Reset pulse during a dm write: bus drops, no completion, owner back to core.
    slv_en = 1'b0;
    dm_addr = 32'h1000_0000; dm_we = 1'b1; dm_size = 2'd2; dm_wdata = 32'hCAFE_F00D;
    dm_left = 1;
    @(posedge clk); #1 dm_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (busy) got = 1'b1;
    end
    check("t6_busy_dm", {busy, grant_dm, s_addr}, {2'b11, 32'h1000_0000});
    @(posedge clk); #1 rst_n = 1'b0; dm_req = 1'b0; dm_left = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); check("t6_after_rst", {s_req, busy, grant_dm}, 3'b000);
    repeat (5) @(negedge clk);
    check("t6_stay_idle", {busy, dm_done, core_done}, 3'b000);
    slv_en = 1'b1;

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
